lc3_decode_stage: RTL and testbench
===================================

LC3_DECODE_STAGE -- requirements
Module: lc3_decode_stage

Interface
REQ-001 clock  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-002 enable_decode  input  1  global stage enable; low freezes all state and blocks both handshakes.
REQ-003 dout  input  16  instruction word from fetch.
REQ-004 npc_in  input  16  PC+1 of dout.
REQ-005 in_valid / in_ready  input / output  1 / 1  fetch handshake; a transfer occurs when both are high at a rising edge.
REQ-006 out_valid / out_ready  output / input  1 / 1  execute handshake; a transfer ("fire") occurs when both are high at a rising edge.
REQ-007 IR  output  16  registered instruction.
REQ-008 npc_out  output  16  registered PC+1.
REQ-009 E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-010 W_Control  output  2  writeback source: 00 ALU/none, 01 memory, 10 pcout.
REQ-011 Mem_Control  output  1  1 = indirect access (LDI/STI).
REQ-012 illegal  output  1  one-cycle pulse; present only under the configuration macro.

Function
REQ-013 alu_control SHALL be 00 for ADD, 01 for AND, 10 for NOT, and 00 for all other opcodes.
REQ-014 pcselect1 SHALL be 01 (offset9) for BR/LD/LDI/LEA/ST/STI, 10 (offset6) for LDR/STR, and 11 (zero) otherwise.
REQ-015 pcselect2 SHALL be 1 (npc) for BR/LD/LDI/LEA/ST/STI, and 0 (base register) otherwise.
REQ-016 op2select SHALL be ~IR[5] for ADD/AND, 1 for NOT, and 0 otherwise.
REQ-017 W_Control SHALL be 01 for LD/LDR/LDI, 10 for LEA, and 00 otherwise; Mem_Control SHALL be 1 only for LDI/STI.
REQ-018 Opcodes 0100, 1000, 1101 and 1111 are illegal; an illegal opcode SHALL decode to E_Control=0, W_Control=0 and Mem_Control=0 (NOP).
REQ-019 Storage SHALL be a main register and a skid register, each holding {IR, npc, decoded controls}; the outputs SHALL always reflect the main register.
REQ-020 The FSM SHALL have three states: EMPTY (no entries held), BUSY (main register full) and FULL (main and skid registers full).
REQ-021 Control outputs SHALL be in_ready = (state != FULL) & enable_decode and out_valid = (state != EMPTY) & enable_decode.
REQ-022 EMPTY: on accept, the FSM SHALL load main and go to BUSY; latency from accept edge to out_valid SHALL be 1 cycle.
REQ-023 BUSY: on accept with fire, main SHALL be replaced and the FSM SHALL stay in BUSY; on accept without fire, the FSM SHALL load skid and go to FULL; on fire without accept, it SHALL go to EMPTY.
REQ-024 FULL: accept is impossible; on fire, the skid contents SHALL move to main and the FSM SHALL go to BUSY.
REQ-025 Order SHALL be strictly FIFO, and sustained throughput SHALL be one instruction per cycle.
REQ-026 When enable_decode=0, no register or state SHALL change.

Reset
REQ-027 During reset, IR, npc_out, E_Control, W_Control, Mem_Control and illegal SHALL be 0; state SHALL be EMPTY; in_ready and out_valid SHALL be 0.
REQ-028 Reset mid-operation SHALL discard both entries with no fire; in_ready SHALL be 1 (given enable_decode=1) in the cycle after reset deasserts.

Configuration
REQ-029 With DECODE_ILLEGAL_DET_EN defined, an illegal opcode accepted SHALL pulse illegal for one cycle, aligned with its first out_valid cycle, and SHALL increment an internal 8-bit saturating count readable as illegal_count[7:0].
REQ-030 Without DECODE_ILLEGAL_DET_EN, the illegal and illegal_count ports SHALL be absent, and illegal opcodes SHALL decode silently as NOP.

Structure
REQ-031 Package lc3_pkg SHALL hold the opcode enum, the ALU op constants (ADD/AND/NOT), the pcselect1 constants, the W_Control constants and the decode-entry struct typedef.
REQ-032 A single combinational sub-module, lc3_decode_lut (IR in; E_Control, W_Control, Mem_Control, illegal out), SHALL be instantiated once, on the input side.

Verification
REQ-033 ADD 0x12A3 with npc_in 0x3001 and out_ready=1 -> next cycle IR=0x12A3, npc_out=0x3001, E_Control=6'b001100, W_Control=00, Mem_Control=0.
REQ-034 ADD 0x1282 (register form) -> E_Control=6'b001101; LDI 0xA403 -> E_Control=6'b000110, W_Control=01, Mem_Control=1.
REQ-035 out_ready=0, then feed 0x5020 and 0x927F -> in_ready=0 after the second accept; then out_ready=1 -> 0x5020 fires, then 0x927F (E_Control=6'b101101), in_ready returns to 1.
REQ-036 Eight back-to-back instructions with out_ready=1 -> eight fires in consecutive cycles starting one cycle after the first accept, in order.
REQ-037 Reset asserted while in FULL -> next cycle out_valid=0, no fire, state EMPTY; the following accept proceeds normally.
REQ-038 0xD000 with the macro defined -> illegal pulses once, illegal_count=1, E_Control=0; without the macro -> E_Control=0, W_Control=0, Mem_Control=0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 decode-stage types: opcodes, control encodings, pipeline entry, FSM states.
package lc3_pkg;

  localparam int unsigned XLEN    = 16;
  localparam int unsigned ECTRL_W = 6;
  localparam int unsigned WCTRL_W = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCS1_NONE = 2'b00;
  localparam logic [1:0] PCS1_OFF9 = 2'b01;
  localparam logic [1:0] PCS1_OFF6 = 2'b10;
  localparam logic [1:0] PCS1_ZERO = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // One decoded instruction as held in the main or skid register.
  typedef struct packed {
    logic [XLEN-1:0]    ir;
    logic [XLEN-1:0]    npc;
    logic [ECTRL_W-1:0] e_ctrl;
    logic [WCTRL_W-1:0] w_ctrl;
    logic               mem_ctrl;
  } decode_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } dec_state_t;

endpackage

// File: rtl/lc3_decode_lut.sv
// Combinational opcode decoder; illegal opcodes decode to an all-zero NOP.
module lc3_decode_lut
  import lc3_pkg::*;
(
  input  logic [XLEN-1:0]    ir_i,
  output logic [ECTRL_W-1:0] e_control_o,
  output logic [WCTRL_W-1:0] w_control_o,
  output logic               mem_control_o,
  output logic               illegal_o
);

  opcode_t    op_c;
  logic [1:0] alu_c;
  logic [1:0] pcs1_c;
  logic       pcs2_c;
  logic       op2_c;
  logic       unused_ir_bits;

  assign op_c           = opcode_t'(ir_i[15:12]);
  assign unused_ir_bits = ^{ir_i[11:6], ir_i[4:0]};
  assign e_control_o    = {alu_c, pcs1_c, pcs2_c, op2_c};

  // Per-opcode control field decode.
  always_comb begin
    alu_c         = ALU_ADD;
    pcs1_c        = PCS1_ZERO;
    pcs2_c        = 1'b0;
    op2_c         = 1'b0;
    w_control_o   = WB_ALU;
    mem_control_o = 1'b0;
    illegal_o     = 1'b0;
    case (op_c)
      OP_ADD: op2_c = ~ir_i[5];
      OP_AND: begin alu_c = ALU_AND; op2_c = ~ir_i[5]; end
      OP_NOT: begin alu_c = ALU_NOT; op2_c = 1'b1; end
      OP_BR, OP_ST: begin pcs1_c = PCS1_OFF9; pcs2_c = 1'b1; end
      OP_LD: begin pcs1_c = PCS1_OFF9; pcs2_c = 1'b1; w_control_o = WB_MEM; end
      OP_LDI: begin
        pcs1_c = PCS1_OFF9; pcs2_c = 1'b1; w_control_o = WB_MEM; mem_control_o = 1'b1;
      end
      OP_STI: begin pcs1_c = PCS1_OFF9; pcs2_c = 1'b1; mem_control_o = 1'b1; end
      OP_LEA: begin pcs1_c = PCS1_OFF9; pcs2_c = 1'b1; w_control_o = WB_PC; end
      OP_LDR: begin pcs1_c = PCS1_OFF6; w_control_o = WB_MEM; end
      OP_STR: pcs1_c = PCS1_OFF6;
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: begin pcs1_c = PCS1_NONE; illegal_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: two-entry (main + skid) elastic buffer around the decode LUT.
// Optional illegal-opcode pulse and saturating count: define DECODE_ILLEGAL_DET_EN.
module lc3_decode_stage
  import lc3_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_decode,
  input  logic [XLEN-1:0]    dout,
  input  logic [XLEN-1:0]    npc_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    IR,
  output logic [XLEN-1:0]    npc_out,
  output logic [ECTRL_W-1:0] E_Control,
  output logic [WCTRL_W-1:0] W_Control,
  output logic               Mem_Control
`ifdef DECODE_ILLEGAL_DET_EN
  ,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_count
`endif
);

  dec_state_t    state_q, state_d;
  decode_entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic          accept, fire, load_main, load_skid, from_skid;
  logic          lut_illegal;

  lc3_decode_lut u_lut (
    .ir_i          (dout),
    .e_control_o   (in_entry.e_ctrl),
    .w_control_o   (in_entry.w_ctrl),
    .mem_control_o (in_entry.mem_ctrl),
    .illegal_o     (lut_illegal)
  );

  assign in_entry.ir  = dout;
  assign in_entry.npc = npc_in;

  // Handshake decode from the held state; both forced low while reset is asserted.
  assign in_ready  = (state_q != ST_FULL)  & enable_decode & ~reset;
  assign out_valid = (state_q != ST_EMPTY) & enable_decode & ~reset;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  assign IR          = main_q.ir;
  assign npc_out     = main_q.npc;
  assign E_Control   = main_q.e_ctrl;
  assign W_Control   = main_q.w_ctrl;
  assign Mem_Control = main_q.mem_ctrl;

  // Next-state and buffer movement.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        main_d = in_entry; load_main = 1'b1; state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (accept && fire) begin
          main_d = in_entry; load_main = 1'b1;
        end else if (accept) begin
          skid_d = in_entry; load_skid = 1'b1; state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (fire) begin
        main_d = skid_q; load_main = 1'b1; from_skid = 1'b1; state_d = ST_BUSY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and entry registers; frozen while the stage is disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (enable_decode) begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DECODE_ILLEGAL_DET_EN
  logic             illegal_q, illegal_d;
  logic             skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign illegal       = illegal_q;
  assign illegal_count = count_q;

  // Pulse on the first output cycle of an illegal entry; count illegal accepts, saturating.
  always_comb begin
    illegal_d  = 1'b0;
    skid_ill_d = skid_ill_q;
    count_d    = count_q;
    if (load_main) illegal_d = from_skid ? skid_ill_q : lut_illegal;
    if (load_skid) skid_ill_d = lut_illegal;
    if (accept && lut_illegal && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  // Illegal-detection registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_q  <= 1'b0;
      skid_ill_q <= 1'b0;
      count_q    <= '0;
    end else if (enable_decode) begin
      illegal_q  <= illegal_d;
      skid_ill_q <= skid_ill_d;
      count_q    <= count_d;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = lut_illegal ^ load_skid ^ from_skid;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed, table-driven bench for lc3_decode_stage.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
`ifdef DECODE_ILLEGAL_DET_EN
  logic        illegal;
  logic [7:0]  illegal_count;
  int          ill_model = 0;
`endif

  lc3_decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control)
`ifdef DECODE_ILLEGAL_DET_EN
    ,
    .illegal       (illegal),
    .illegal_count (illegal_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable_decode = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dout = '0; npc_in = '0;

    vecs[0]  = '{16'h12A3, 16'h3001, 6'b001100, 2'b00, 1'b0, 1'b0}; // ADD imm
    vecs[1]  = '{16'h1282, 16'h3002, 6'b001101, 2'b00, 1'b0, 1'b0}; // ADD reg
    vecs[2]  = '{16'hA403, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0}; // LDI
    vecs[3]  = '{16'h5020, 16'h3004, 6'b011100, 2'b00, 1'b0, 1'b0}; // AND imm
    vecs[4]  = '{16'h5042, 16'h3005, 6'b011101, 2'b00, 1'b0, 1'b0}; // AND reg
    vecs[5]  = '{16'h927F, 16'h3006, 6'b101101, 2'b00, 1'b0, 1'b0}; // NOT
    vecs[6]  = '{16'h0E05, 16'h3007, 6'b000110, 2'b00, 1'b0, 1'b0}; // BR
    vecs[7]  = '{16'h2205, 16'h3008, 6'b000110, 2'b01, 1'b0, 1'b0}; // LD
    vecs[8]  = '{16'h6283, 16'h3009, 6'b001000, 2'b01, 1'b0, 1'b0}; // LDR
    vecs[9]  = '{16'h7283, 16'h300A, 6'b001000, 2'b00, 1'b0, 1'b0}; // STR
    vecs[10] = '{16'h3205, 16'h300B, 6'b000110, 2'b00, 1'b0, 1'b0}; // ST
    vecs[11] = '{16'hB205, 16'h300C, 6'b000110, 2'b00, 1'b1, 1'b0}; // STI
    vecs[12] = '{16'hE205, 16'h300D, 6'b000110, 2'b10, 1'b0, 1'b0}; // LEA
    vecs[13] = '{16'hC1C0, 16'h300E, 6'b001100, 2'b00, 1'b0, 1'b0}; // JMP
    vecs[14] = '{16'hD000, 16'h300F, 6'b000000, 2'b00, 1'b0, 1'b1}; // reserved
    vecs[15] = '{16'h4800, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b1}; // JSR
    vecs[16] = '{16'h8000, 16'h3011, 6'b000000, 2'b00, 1'b0, 1'b1}; // RTI
    vecs[17] = '{16'hF025, 16'h3012, 6'b000000, 2'b00, 1'b0, 1'b1}; // TRAP

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_IR", IR, 16'h0);
    chk("rst_npc", npc_out, 16'h0);
    chk("rst_E", 16'(E_Control), 16'h0);
    chk("rst_W", 16'(W_Control), 16'h0);
    chk("rst_M", 16'(Mem_Control), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
`ifdef DECODE_ILLEGAL_DET_EN
    chk("rst_illegal", 16'(illegal), 16'h0);
`endif
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 16'(in_ready), 16'h1);
    chk("post_rst_out_valid", 16'(out_valid), 16'h0);

    // Single instructions through the table
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; dout = vecs[i].instr; npc_in = vecs[i].npc; out_ready = 1'b1;
      @(posedge clock); #1 in_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d_valid", i), 16'(out_valid), 16'h1);
      chk($sformatf("v%0d_IR", i), IR, vecs[i].instr);
      chk($sformatf("v%0d_npc", i), npc_out, vecs[i].npc);
      chk($sformatf("v%0d_E", i), 16'(E_Control), 16'(vecs[i].e));
      chk($sformatf("v%0d_W", i), 16'(W_Control), 16'(vecs[i].w));
      chk($sformatf("v%0d_M", i), 16'(Mem_Control), 16'(vecs[i].m));
`ifdef DECODE_ILLEGAL_DET_EN
      chk($sformatf("v%0d_illegal", i), 16'(illegal), 16'(vecs[i].ill));
      if (vecs[i].ill) ill_model++;
`endif
      @(posedge clock); #1;
      @(negedge clock);
      chk($sformatf("v%0d_drained", i), 16'(out_valid), 16'h0);
`ifdef DECODE_ILLEGAL_DET_EN
      chk($sformatf("v%0d_illegal_off", i), 16'(illegal), 16'h0);
`endif
    end

    // Backpressure fills main then skid
    @(posedge clock); #1;
    out_ready = 1'b0; in_valid = 1'b1; dout = 16'h5020; npc_in = 16'h4001;
    @(posedge clock); #1 dout = 16'h927F; npc_in = 16'h4002;
    @(negedge clock);
    chk("bp_busy_in_ready", 16'(in_ready), 16'h1);
    chk("bp_busy_IR", IR, 16'h5020);
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    chk("bp_full_in_ready", 16'(in_ready), 16'h0);
    chk("bp_full_out_valid", 16'(out_valid), 16'h1);
    chk("bp_full_IR", IR, 16'h5020);

    // Disabled stage holds everything
    enable_decode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; dout = 16'h1111;
    #1;
    chk("dis_out_valid", 16'(out_valid), 16'h0);
    chk("dis_in_ready", 16'(in_ready), 16'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("dis_IR_held", IR, 16'h5020);
    enable_decode = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("dis_still_full", 16'(in_ready), 16'h0);
    chk("dis_valid_back", 16'(out_valid), 16'h1);

    // Drain in FIFO order
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_second_IR", IR, 16'h927F);
    chk("bp_second_npc", npc_out, 16'h4002);
    chk("bp_second_E", 16'(E_Control), 16'(6'b101101));
    chk("bp_in_ready_back", 16'(in_ready), 16'h1);
    chk("bp_second_valid", 16'(out_valid), 16'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_empty", 16'(out_valid), 16'h0);

    // Eight back-to-back instructions
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; dout = 16'h1000 + 16'(k); npc_in = 16'h6000 + 16'(k);
      @(negedge clock);
      chk($sformatf("b2b%0d_in_ready", k), 16'(in_ready), 16'h1);
      if (k == 0) begin
        chk("b2b0_valid", 16'(out_valid), 16'h0);
      end else begin
        chk($sformatf("b2b%0d_valid", k), 16'(out_valid), 16'h1);
        chk($sformatf("b2b%0d_IR", k), IR, 16'h1000 + 16'(k - 1));
        chk($sformatf("b2b%0d_npc", k), npc_out, 16'h6000 + 16'(k - 1));
      end
    end
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_last_valid", 16'(out_valid), 16'h1);
    chk("b2b_last_IR", IR, 16'h1007);
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_drained", 16'(out_valid), 16'h0);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    @(posedge clock); #1 in_valid = 1'b1; dout = 16'hA403; npc_in = 16'h7001;
    @(posedge clock); #1 dout = 16'h12A3; npc_in = 16'h7002;
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    chk("rf_full", 16'(in_ready), 16'h0);
    out_ready = 1'b1; reset = 1'b1;
    #1;
    chk("rf_no_fire", 16'(out_valid), 16'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rf_empty_valid", 16'(out_valid), 16'h0);
    chk("rf_in_ready", 16'(in_ready), 16'h1);
    chk("rf_IR_cleared", IR, 16'h0);
    @(posedge clock); #1 in_valid = 1'b1; dout = 16'h1282; npc_in = 16'h5001;
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    chk("rf_after_valid", 16'(out_valid), 16'h1);
    chk("rf_after_IR", IR, 16'h1282);
    chk("rf_after_E", 16'(E_Control), 16'(6'b001101));
    @(posedge clock); #1;
    @(negedge clock);
    chk("rf_after_drained", 16'(out_valid), 16'h0);

`ifdef DECODE_ILLEGAL_DET_EN
    chk("illegal_count", 16'(illegal_count), 16'(ill_model));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
